// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Sequences the PC, the IF/ID
//               register and the ID/EX stage for three hazards:
//                 - load-use        : one-cycle stall with a bubble into ID/EX
//                 - MUL/DIV in EX   : EX held for MD_LATENCY-1 cycles
//                 - taken branch/jmp: wrong-path IF/ID instruction flushed
//               Also keeps saturating stall/flush event counters.
// Ports       : clk, rst            clock, synchronous active-high reset
//               ID_rs/ID_rt         source fields of the instruction in ID
//               ID_uses_rs/rt       ID instruction actually reads rs/rt
//               ID_EX_MemRead/rt    load in EX and its destination register
//               EX_md_start         MUL/DIV in its first EX cycle
//               branch_taken/jump   control transfer resolved in ID
//               PCWrite/IF_ID_Write 0 = hold PC / IF/ID register
//               IF_Flush            1 = zero the IF/ID instruction
//               ID_EX_Bubble        1 = load a NOP into ID/EX
//               EX_hold             1 = freeze ID/EX and EX
//               stall_cnt/flush_cnt saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rt,
    input  logic             EX_md_start,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_Flush,
    output logic             ID_EX_Bubble,
    output logic             EX_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] c_ST_RUN     = 1'b0;
    localparam logic [0:0] c_ST_MD_BUSY = 1'b1;

    // Latency 1 never holds; latency 2 holds only on the start cycle, so the
    // FSM is needed only from latency 3 upward.
    localparam bit c_MD_HOLDS = (MD_LATENCY >= 2);
    localparam bit c_MD_FSM   = (MD_LATENCY >= 3);

    // md_cnt holds at most MD_LATENCY-2, which always fits in clog2(MD_LATENCY).
    localparam int              c_MD_W    = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [c_MD_W-1:0] c_MD_LOAD = c_MD_W'((MD_LATENCY >= 2) ? (MD_LATENCY - 2) : 0);
    localparam logic [c_MD_W-1:0] c_MD_ONE  = c_MD_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

    logic [0:0]        r_state_q;
    logic [0:0]        w_state_d;
    logic [c_MD_W-1:0] r_md_cnt_q;
    logic [c_MD_W-1:0] w_md_cnt_d;
    logic [CNT_W-1:0]  r_stall_cnt_q;
    logic [CNT_W-1:0]  w_stall_cnt_d;
    logic [CNT_W-1:0]  r_flush_cnt_q;
    logic [CNT_W-1:0]  w_flush_cnt_d;

    logic w_lu;
    logic w_mdh;
    logic w_br;

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    always_comb begin
        // r0 is hard-wired zero, so a load to r0 never creates a dependency.
        w_lu  = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
                ((ID_uses_rs && (ID_EX_rt == ID_rs)) ||
                 (ID_uses_rt && (ID_EX_rt == ID_rt)));
        w_mdh = ((r_state_q == c_ST_RUN) && EX_md_start && c_MD_HOLDS) ||
                (r_state_q == c_ST_MD_BUSY);
        w_br  = branch_taken || jump;
    end

    // ------------------------------------------------------------------------
    // Control outputs, priority mdh > lu > br. Reset forces the run values so
    // the pipeline is never frozen while being cleared. A stalled branch stays
    // in ID and is flushed on the cycle it is finally released.
    // ------------------------------------------------------------------------
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_Flush     = 1'b0;
        ID_EX_Bubble = 1'b0;
        EX_hold      = 1'b0;
        if (!rst) begin
            if (w_mdh) begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                EX_hold     = 1'b1;
            end else if (w_lu) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
            end else if (w_br) begin
                IF_Flush = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // MUL/DIV occupancy FSM. The start cycle is held from RUN; MD_BUSY then
    // covers the remaining MD_LATENCY-2 cycles, leaving on md_cnt == 1.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_md_cnt_d = r_md_cnt_q;
        case (r_state_q)
            c_ST_RUN: begin
                if (EX_md_start && c_MD_FSM) begin
                    w_state_d  = c_ST_MD_BUSY;
                    w_md_cnt_d = c_MD_LOAD;
                end
            end
            c_ST_MD_BUSY: begin
                w_md_cnt_d = r_md_cnt_q - c_MD_ONE;
                if (r_md_cnt_q == c_MD_ONE) begin
                    w_state_d = c_ST_RUN;
                end
            end
            default: begin
                w_state_d  = c_ST_RUN;
                w_md_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------------
    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (!PCWrite && (r_stall_cnt_q != c_CNT_MAX)) begin
            w_stall_cnt_d = r_stall_cnt_q + 1'b1;
        end
        if (IF_Flush && (r_flush_cnt_q != c_CNT_MAX)) begin
            w_flush_cnt_d = r_flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_ST_RUN;
            r_md_cnt_q    <= '0;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_md_cnt_q    <= w_md_cnt_d;
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign stall_cnt = r_stall_cnt_q;
    assign flush_cnt = r_flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Three instances with
//               different MD_LATENCY/CNT_W share one stimulus stream; a
//               cycle-level model checks every output of every instance on
//               each falling edge, and literal checks pin key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] ID_rs, ID_rt, ID_EX_rt;
    logic       ID_uses_rs, ID_uses_rt, ID_EX_MemRead, EX_md_start, branch_taken, jump;

    // Instance 0: MD_LATENCY=4 CNT_W=16; 1: MD_LATENCY=2 CNT_W=2; 2: MD_LATENCY=1 CNT_W=16
    logic        a_pcw, a_ifid, a_fl, a_bub, a_hold;
    logic        b_pcw, b_ifid, b_fl, b_bub, b_hold;
    logic        c_pcw, c_ifid, c_fl, c_bub, c_hold;
    logic [15:0] a_sc, a_fc, c_sc, c_fc;
    logic [1:0]  b_sc, b_fc;

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs),
        .ID_uses_rt(ID_uses_rt), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
        .EX_md_start(EX_md_start), .branch_taken(branch_taken), .jump(jump),
        .PCWrite(a_pcw), .IF_ID_Write(a_ifid), .IF_Flush(a_fl), .ID_EX_Bubble(a_bub),
        .EX_hold(a_hold), .stall_cnt(a_sc), .flush_cnt(a_fc));

    hazard_ctrl #(.MD_LATENCY(2), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs),
        .ID_uses_rt(ID_uses_rt), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
        .EX_md_start(EX_md_start), .branch_taken(branch_taken), .jump(jump),
        .PCWrite(b_pcw), .IF_ID_Write(b_ifid), .IF_Flush(b_fl), .ID_EX_Bubble(b_bub),
        .EX_hold(b_hold), .stall_cnt(b_sc), .flush_cnt(b_fc));

    hazard_ctrl #(.MD_LATENCY(1), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs),
        .ID_uses_rt(ID_uses_rt), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
        .EX_md_start(EX_md_start), .branch_taken(branch_taken), .jump(jump),
        .PCWrite(c_pcw), .IF_ID_Write(c_ifid), .IF_Flush(c_fl), .ID_EX_Bubble(c_bub),
        .EX_hold(c_hold), .stall_cnt(c_sc), .flush_cnt(c_fc));

    logic        pcw_o[3], ifid_o[3], fl_o[3], bub_o[3], hold_o[3];
    logic [15:0] sc_o[3], fc_o[3];
    assign pcw_o[0] = a_pcw;  assign pcw_o[1] = b_pcw;  assign pcw_o[2] = c_pcw;
    assign ifid_o[0] = a_ifid; assign ifid_o[1] = b_ifid; assign ifid_o[2] = c_ifid;
    assign fl_o[0] = a_fl;    assign fl_o[1] = b_fl;    assign fl_o[2] = c_fl;
    assign bub_o[0] = a_bub;  assign bub_o[1] = b_bub;  assign bub_o[2] = c_bub;
    assign hold_o[0] = a_hold; assign hold_o[1] = b_hold; assign hold_o[2] = c_hold;
    assign sc_o[0] = a_sc;    assign sc_o[1] = 16'(b_sc); assign sc_o[2] = c_sc;
    assign fc_o[0] = a_fc;    assign fc_o[1] = 16'(b_fc); assign fc_o[2] = c_fc;

    int     tests = 0;
    int     fails = 0;
    bit     chk_en = 1'b0;

    task automatic chk(input string nm, input int idx, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s inst%0d @%0t: got %0d, expected %0d", nm, idx, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: per instance, the number of further hold cycles still owed after
    // the current one, plus plain integer event counts clamped to 2^CNT_W-1.
    // ------------------------------------------------------------------------
    int     lat[3] = '{4, 2, 1};
    int     cw[3]  = '{16, 2, 16};
    int     rem[3] = '{0, 0, 0};
    longint sc[3]  = '{0, 0, 0};
    longint fc[3]  = '{0, 0, 0};
    bit     m_lu, m_br, m_hold, m_stall, m_flush;
    longint m_max;

    always @(negedge clk) begin
        if (chk_en) begin
            m_lu = ID_EX_MemRead && (ID_EX_rt != 0) &&
                   ((ID_uses_rs && ID_EX_rt == ID_rs) || (ID_uses_rt && ID_EX_rt == ID_rt));
            m_br = branch_taken || jump;
            for (int i = 0; i < 3; i++) begin
                m_hold  = !rst && (rem[i] > 0 || (EX_md_start && lat[i] >= 2));
                m_stall = !rst && !m_hold && m_lu;
                m_flush = !rst && !m_hold && !m_stall && m_br;
                chk("PCWrite",      i, pcw_o[i],  !(m_hold || m_stall));
                chk("IF_ID_Write",  i, ifid_o[i], !(m_hold || m_stall));
                chk("IF_Flush",     i, fl_o[i],   m_flush);
                chk("ID_EX_Bubble", i, bub_o[i],  m_stall);
                chk("EX_hold",      i, hold_o[i], m_hold);
                chk("stall_cnt",    i, sc_o[i],   sc[i]);
                chk("flush_cnt",    i, fc_o[i],   fc[i]);
                m_max = (longint'(1) << cw[i]) - 1;
                if (rst) begin
                    rem[i] = 0; sc[i] = 0; fc[i] = 0;
                end else begin
                    if (rem[i] > 0)                          rem[i] = rem[i] - 1;
                    else if (m_hold)                         rem[i] = lat[i] - 2;
                    if ((m_hold || m_stall) && sc[i] < m_max) sc[i] = sc[i] + 1;
                    if (m_flush && fc[i] < m_max)            fc[i] = fc[i] + 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after a rising edge, are checked at
    // the falling edge and take effect at the next rising edge.
    // ------------------------------------------------------------------------
    task automatic tick();   @(posedge clk); #1; endtask
    task automatic settle(); @(negedge clk); #1; endtask
    task automatic clr();
        ID_rs = 0; ID_rt = 0; ID_EX_rt = 0; ID_uses_rs = 0; ID_uses_rt = 0;
        ID_EX_MemRead = 0; EX_md_start = 0; branch_taken = 0; jump = 0;
    endtask
    task automatic set_lu(input bit mr, input logic [4:0] ert, input bit urs,
                          input logic [4:0] rs, input bit urt, input logic [4:0] rt);
        ID_EX_MemRead = mr; ID_EX_rt = ert; ID_uses_rs = urs; ID_rs = rs;
        ID_uses_rt = urt; ID_rt = rt;
    endtask

    typedef struct packed {
        logic mr; logic [4:0] ert; logic urs; logic [4:0] rs; logic urt; logic [4:0] rt; logic stall;
    } lu_vec_t;
    lu_vec_t lu_tab[6] = '{
        '{1'b1, 5'd5,  1'b0, 5'd5,  1'b0, 5'd5,  1'b0},  // match but no source read
        '{1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 5'd5,  1'b1},  // rt dependency
        '{1'b0, 5'd5,  1'b1, 5'd5,  1'b1, 5'd5,  1'b0},  // not a load
        '{1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  1'b0},  // load to r0
        '{1'b1, 5'd31, 1'b1, 5'd31, 1'b0, 5'd0,  1'b1},  // rs dependency, r31
        '{1'b1, 5'd7,  1'b1, 5'd6,  1'b1, 5'd8,  1'b0}   // no register match
    };

    initial begin
        clr(); rst = 1'b1;
        tick(); chk_en = 1'b1;
        settle(); chk("rst_PCWrite", 0, a_pcw, 1); chk("rst_EX_hold", 0, a_hold, 0);
        tick(); rst = 1'b0;
        settle(); chk("reset_stall_cnt", 0, a_sc, 0); chk("reset_flush_cnt", 0, a_fc, 0);
        tick();

        // Load-use on rs: one stall cycle with a bubble
        set_lu(1, 5'd5, 1, 5'd5, 0, 5'd0);
        settle(); chk("lu_PCWrite", 0, a_pcw, 0); chk("lu_IF_ID_Write", 0, a_ifid, 0);
        chk("lu_Bubble", 0, a_bub, 1);
        tick(); clr();
        settle(); chk("lu_stall_cnt", 0, a_sc, 1); chk("lu_done_PCWrite", 0, a_pcw, 1);
        tick();

        // Table of load-use patterns (two stalls -> stall_cnt 3; CNT_W=2 saturates at 3)
        foreach (lu_tab[k]) begin
            set_lu(lu_tab[k].mr, lu_tab[k].ert, lu_tab[k].urs, lu_tab[k].rs, lu_tab[k].urt, lu_tab[k].rt);
            settle(); chk("lu_tab_Bubble", k, a_bub, lu_tab[k].stall);
            tick();
        end
        clr();
        settle(); chk("lu_tab_stall_cnt", 0, a_sc, 3); chk("sat_stall_cnt", 1, b_sc, 3);
        tick();

        // MUL/DIV: start held two cycles, the second start is ignored by MD_LATENCY=4
        EX_md_start = 1;
        settle(); chk("md_hold_c1", 0, a_hold, 1); chk("md_lat1_hold", 2, c_hold, 0);
        tick();
        settle(); chk("md_hold_c2", 0, a_hold, 1);
        tick(); EX_md_start = 0;
        settle(); chk("md_hold_c3", 0, a_hold, 1); chk("md_lat2_free", 1, b_hold, 0);
        tick();
        settle(); chk("md_hold_c4", 0, a_hold, 0); chk("md_after_PCWrite", 0, a_pcw, 1);
        chk("md_stall_cnt", 0, a_sc, 6);
        tick();

        // Taken branch, no hazard
        branch_taken = 1;
        settle(); chk("br_IF_Flush", 0, a_fl, 1); chk("br_PCWrite", 0, a_pcw, 1);
        tick(); clr();
        settle(); chk("br_flush_cnt", 0, a_fc, 1);
        tick();

        // Branch masked by load-use, then flushed once the stall clears
        branch_taken = 1; set_lu(1, 5'd9, 1, 5'd9, 0, 5'd0);
        settle(); chk("brlu_IF_Flush", 0, a_fl, 0); chk("brlu_PCWrite", 0, a_pcw, 0);
        tick(); ID_EX_MemRead = 0;
        settle(); chk("brlu_next_IF_Flush", 0, a_fl, 1);
        tick(); clr();

        // Branch masked by a MUL/DIV hold for its full length
        EX_md_start = 1; jump = 1;
        settle(); chk("brmd_IF_Flush", 0, a_fl, 0);
        tick(); EX_md_start = 0;
        tick(); tick();
        settle(); chk("brmd_release_IF_Flush", 0, a_fl, 1);
        tick(); clr();

        // Three more jumps: CNT_W=2 flush counter saturates
        jump = 1;
        repeat (3) tick();
        clr();
        settle(); chk("jmp_flush_cnt", 0, a_fc, 6); chk("sat_flush_cnt", 1, b_fc, 3);
        tick();

        // Reset while MD_BUSY with cycles still owed aborts the hold
        EX_md_start = 1;
        tick(); EX_md_start = 0; rst = 1;
        settle(); chk("rstbusy_EX_hold", 0, a_hold, 0); chk("rstbusy_PCWrite", 0, a_pcw, 1);
        tick(); rst = 0;
        settle(); chk("postrst_EX_hold", 0, a_hold, 0); chk("postrst_stall_cnt", 0, a_sc, 0);
        chk("postrst_flush_cnt", 0, a_fc, 0);
        tick();

        // Counting resumes from zero
        set_lu(1, 5'd3, 0, 5'd0, 1, 5'd3);
        tick(); clr();
        settle(); chk("recount_stall_cnt", 0, a_sc, 1);
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
